// File: rtl/osd_pkg.sv
// Shared definitions for the OSD command bus: overlay opcodes and scheduler state encoding.
package osd_pkg;

    localparam int unsigned OSD_CMD_W = 16;

    localparam logic [7:0] OSD_OP_NOP       = 8'h00;
    localparam logic [7:0] OSD_OP_OVERLAY   = 8'h01;
    localparam logic [7:0] OSD_OP_POPUP     = 8'h02;
    localparam logic [7:0] OSD_OP_X         = 8'h10;
    localparam logic [7:0] OSD_OP_Y         = 8'h11;
    localparam logic [7:0] OSD_OP_CHAR      = 8'h12;
    localparam logic [7:0] OSD_OP_ATTR      = 8'h13;
    localparam logic [7:0] OSD_OP_FONT_RST  = 8'h20;
    localparam logic [7:0] OSD_OP_FONT_DATA = 8'h21;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEP   = 2'd1,
        ST_ISSUE = 2'd2,
        ST_WAIT  = 2'd3
    } osd_state_e;

    // Undecoded opcode with an inverted low byte: a visible bus change with no overlay effect.
    function automatic logic [OSD_CMD_W-1:0] osd_sep_word(input logic [OSD_CMD_W-1:0] cur);
        return {OSD_OP_NOP, ~cur[7:0]};
    endfunction

endpackage

// File: rtl/osd_rr_arb2.sv
// Two-way round-robin arbiter with burst lock; the pointer moves past the owner on release.
module osd_rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic       idle_i,
    input  logic       wait_i,
    input  logic [1:0] grant_i,
    input  logic       a_valid_i,
    input  logic       b_valid_i,
    input  logic       release_i,
    output logic       a_ready_c,
    output logic       b_ready_c
);

    logic ptr_q, ptr_d;   // 0: A has priority, 1: B has priority

    always_comb begin
        ptr_d = ptr_q;
        if (release_i) begin
            ptr_d = ~grant_i[1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign a_ready_c = a_valid_i & ((idle_i & (~b_valid_i | ~ptr_q)) | (wait_i & grant_i[0]));
    assign b_ready_c = b_valid_i & ((idle_i & (~a_valid_i |  ptr_q)) | (wait_i & grant_i[1]));

endmodule

// File: rtl/osd_cmd_sched.sv
// OSD command bus scheduler: arbitrates two requesters, keeps bursts atomic, holds each word
// for HOLD_CYCLES and inserts a separator when a word repeats the current bus value.
module osd_cmd_sched #(
    parameter int unsigned HOLD_CYCLES  = 2,
    parameter int unsigned LOCK_TIMEOUT = 4096,
    parameter int unsigned TMR_W        = 13
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] a_cmd,
    input  logic        a_valid,
    input  logic        a_last,
    output logic        a_ready,
    input  logic [15:0] b_cmd,
    input  logic        b_valid,
    input  logic        b_last,
    output logic        b_ready,
    output logic [15:0] osd_command,
    output logic        busy,
    output logic [1:0]  grant
);

    import osd_pkg::*;

    localparam logic [TMR_W-1:0] HOLD_LD = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] TO_LAST = TMR_W'(LOCK_TIMEOUT - 1);

    osd_state_e         state_q, state_d;
    logic [15:0]        cmd_q, cmd_d;
    logic [15:0]        word_q, word_d;
    logic               last_q, last_d;
    logic [1:0]         grant_q, grant_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic               busy_q;
    logic               a_acc, b_acc, rel;
    logic [15:0]        in_word;
    logic               in_last;

    osd_rr_arb2 u_arb (
        .clk       (clk),
        .reset     (reset),
        .idle_i    (state_q == ST_IDLE),
        .wait_i    (state_q == ST_WAIT),
        .grant_i   (grant_q),
        .a_valid_i (a_valid),
        .b_valid_i (b_valid),
        .release_i (rel),
        .a_ready_c (a_ready),
        .b_ready_c (b_ready)
    );

    assign a_acc   = a_valid & a_ready;
    assign b_acc   = b_valid & b_ready;
    assign in_word = b_acc ? b_cmd  : a_cmd;
    assign in_last = b_acc ? b_last : a_last;

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        word_d  = word_q;
        last_d  = last_q;
        grant_d = grant_q;
        tmr_d   = tmr_q;
        rel     = 1'b0;
        case (state_q)
            ST_IDLE, ST_WAIT: begin
                if (a_acc || b_acc) begin
                    word_d  = in_word;
                    last_d  = in_last;
                    grant_d = b_acc ? 2'b10 : 2'b01;
                    tmr_d   = HOLD_LD;
                    if (in_word == cmd_q) begin
                        cmd_d   = osd_sep_word(cmd_q);
                        state_d = ST_SEP;
                    end else begin
                        cmd_d   = in_word;
                        state_d = ST_ISSUE;
                    end
                end else if (state_q == ST_WAIT && LOCK_TIMEOUT != 0) begin
                    // Owner went quiet mid-burst: drop the lock so the other side is not starved.
                    if (tmr_q == TO_LAST) begin
                        grant_d = 2'b00;
                        rel     = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        tmr_d = tmr_q + TMR_W'(1);
                    end
                end
            end
            ST_SEP: begin
                if (tmr_q == '0) begin
                    cmd_d   = word_q;
                    tmr_d   = HOLD_LD;
                    state_d = ST_ISSUE;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            ST_ISSUE: begin
                if (tmr_q == '0) begin
                    if (last_q) begin
                        grant_d = 2'b00;
                        rel     = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        tmr_d   = '0;
                        state_d = ST_WAIT;
                    end
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cmd_q   <= '0;
            word_q  <= '0;
            last_q  <= 1'b0;
            grant_q <= 2'b00;
            tmr_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            word_q  <= word_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            tmr_q   <= tmr_d;
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    assign osd_command = cmd_q;
    assign grant       = grant_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_osd_cmd_sched.sv
// Directed bench for osd_cmd_sched: bus word sequences, hold lengths, arbitration, lock timeout, reset.
module tb_osd_cmd_sched;

    logic        clk;
    logic        reset;
    logic [15:0] a_cmd, b_cmd;
    logic        a_valid, a_last, a_ready;
    logic        b_valid, b_last, b_ready;
    logic [15:0] osd_command;
    logic        busy;
    logic [1:0]  grant;

    int n_chk = 0;
    int n_bad = 0;

    logic [15:0] tv[$];
    int          tl[$];

    osd_cmd_sched dut (
        .clk         (clk),
        .reset       (reset),
        .a_cmd       (a_cmd),
        .a_valid     (a_valid),
        .a_last      (a_last),
        .a_ready     (a_ready),
        .b_cmd       (b_cmd),
        .b_valid     (b_valid),
        .b_last      (b_last),
        .b_ready     (b_ready),
        .osd_command (osd_command),
        .busy        (busy),
        .grant       (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Run-length trace of the bus value, one sample per cycle.
    always @(negedge clk) begin
        if (tv.size() == 0 || osd_command != tv[tv.size()-1]) begin
            tv.push_back(osd_command);
            tl.push_back(1);
        end else begin
            tl[tl.size()-1] = tl[tl.size()-1] + 1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic clr_trace();
        tv.delete();
        tl.delete();
    endtask

    task automatic send(input bit rb, input logic [15:0] c, input logic l, input int budget,
                        output bit ok, output logic [1:0] g, output logic [15:0] bus);
        @(negedge clk);
        if (rb) begin b_cmd = c; b_last = l; b_valid = 1'b1; end
        else    begin a_cmd = c; a_last = l; a_valid = 1'b1; end
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            #1;
            if (rb ? b_ready : a_ready) ok = 1'b1;
            else @(negedge clk);
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end
        if (rb) b_valid = 1'b0;
        else    a_valid = 1'b0;
        g   = grant;
        bus = osd_command;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        bit          ok, okb, oka;
        logic [1:0]  g, gb;
        logic [15:0] bus, busb;
        logic [15:0] burst [4];
        logic [15:0] ex2 [6];
        logic [15:0] ex3 [7];

        reset = 1'b1;
        a_cmd = '0; a_valid = 1'b0; a_last = 1'b0;
        b_cmd = '0; b_valid = 1'b0; b_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd",   32'(osd_command), 32'h0000);
        chk("rst_grant", 32'(grant),       32'd0);
        chk("rst_busy",  32'(busy),        32'd0);
        chk("rst_ardy",  32'(a_ready),     32'd0);
        chk("rst_brdy",  32'(b_ready),     32'd0);
        @(negedge clk);
        reset = 1'b0;

        // single A word: on bus one cycle after accept, held two cycles
        @(posedge clk); #1;
        clr_trace();
        send(1'b0, 16'h0101, 1'b1, 20, ok, g, bus);
        chk("t1_acc",   32'(ok),   32'd1);
        chk("t1_lat",   32'(bus),  32'h0101);
        chk("t1_grant", 32'(g),    32'd1);
        chk("t1_busy",  32'(busy), 32'd1);
        @(posedge clk); #1;
        chk("t1_hold",  32'(busy), 32'd1);
        @(posedge clk); #1;
        chk("t1_done",  32'(busy),        32'd0);
        chk("t1_ungr",  32'(grant),       32'd0);
        chk("t1_bus",   32'(osd_command), 32'h0101);

        // pointer now at B: simultaneous request goes to B first
        clr_trace();
        fork
            send(1'b0, 16'h0102, 1'b1, 40, ok,  g,  bus);
            send(1'b1, 16'h0203, 1'b1, 40, okb, gb, busb);
        join
        wait_idle("t1b_idle", 20);
        chk("t1b_gb",  32'(gb),    32'd2);
        chk("t1b_ga",  32'(g),     32'd1);
        chk("t1b_w1",  32'(tv[1]), 32'h0203);
        chk("t1b_w2",  32'(tv[2]), 32'h0102);

        // locked A burst with B stalled behind it
        burst = '{16'h1005, 16'h1103, 16'h1241, 16'h1347};
        ex2   = '{16'h0102, 16'h1005, 16'h1103, 16'h1241, 16'h1347, 16'h0201};
        clr_trace();
        oka = 1'b1;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    send(1'b0, burst[i], (i == 3), 40, ok, g, bus);
                    oka = oka & ok;
                end
            end
            begin
                repeat (2) @(negedge clk);
                send(1'b1, 16'h0201, 1'b1, 200, okb, gb, busb);
            end
        join
        wait_idle("t2_idle", 20);
        chk("t2_acc_a", 32'(oka), 32'd1);
        chk("t2_gb",    32'(gb),  32'd2);
        chk("t2_n",     32'(tv.size()), 32'd6);
        for (int i = 0; i < 6; i++) chk($sformatf("t2_w%0d", i), 32'(tv[i]), 32'(ex2[i]));
        chk("t2_rate",  32'(tl[2]), 32'd3);

        // pointer back at A: simultaneous request goes to A first
        clr_trace();
        fork
            send(1'b0, 16'h0102, 1'b1, 40, ok,  g,  bus);
            send(1'b1, 16'h0203, 1'b1, 40, okb, gb, busb);
        join
        wait_idle("t4_idle", 20);
        chk("t4_ga", 32'(g),     32'd1);
        chk("t4_gb", 32'(gb),    32'd2);
        chk("t4_w1", 32'(tv[1]), 32'h0102);
        chk("t4_w2", 32'(tv[2]), 32'h0203);

        // font stream with repeated bytes needs separators
        ex3 = '{16'h0203, 16'h2001, 16'h21AA, 16'h0055, 16'h21AA, 16'h0055, 16'h21AA};
        clr_trace();
        send(1'b0, 16'h2001, 1'b0, 40, ok, g, bus);
        send(1'b0, 16'h21AA, 1'b0, 40, ok, g, bus);
        send(1'b0, 16'h21AA, 1'b0, 40, ok, g, bus);
        chk("t3_sep_now", 32'(bus), 32'h0055);
        send(1'b0, 16'h21AA, 1'b1, 40, ok, g, bus);
        wait_idle("t3_idle", 20);
        chk("t3_n", 32'(tv.size()), 32'd7);
        for (int i = 0; i < 7; i++) chk($sformatf("t3_w%0d", i), 32'(tv[i]), 32'(ex3[i]));
        chk("t3_sep1_len", 32'(tl[3]), 32'd2);
        chk("t3_sep2_len", 32'(tl[5]), 32'd2);

        // lock timeout: A stalls mid-burst, B pending is served after the release
        clr_trace();
        fork
            send(1'b0, 16'h1005, 1'b0, 40, ok, g, bus);
            begin
                repeat (3) @(negedge clk);
                send(1'b1, 16'h0304, 1'b1, 5000, okb, gb, busb);
            end
            begin
                repeat (100) @(posedge clk);
                #1;
                chk("t5_locked", 32'(grant),       32'd1);
                chk("t5_bus",    32'(osd_command), 32'h1005);
                chk("t5_bstall", 32'(b_ready),     32'd0);
            end
        join
        wait_idle("t5_idle", 20);
        chk("t5_accb", 32'(okb),   32'd1);
        chk("t5_gb",   32'(gb),    32'd2);
        chk("t5_busb", 32'(busb),  32'h0304);
        chk("t5_w1",   32'(tv[1]), 32'h1005);
        chk("t5_len",  32'(tl[1]), 32'd4099);
        chk("t5_w2",   32'(tv[2]), 32'h0304);

        // reset while a separator is on the bus
        send(1'b0, 16'h0304, 1'b0, 40, ok, g, bus);
        chk("t6_sep",  32'(bus),  32'h00FB);
        chk("t6_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("t6_rcmd",   32'(osd_command), 32'h0000);
        chk("t6_rgrant", 32'(grant),       32'd0);
        chk("t6_rbusy",  32'(busy),        32'd0);
        clr_trace();
        @(negedge clk);
        reset = 1'b0;
        send(1'b0, 16'h0000, 1'b1, 40, ok, g, bus);
        chk("t6_sep0", 32'(bus), 32'h00FF);
        wait_idle("t6_idle", 20);
        chk("t6_w0",  32'(tv[0]), 32'h0000);
        chk("t6_w1",  32'(tv[1]), 32'h00FF);
        chk("t6_len", 32'(tl[1]), 32'd2);
        chk("t6_w2",  32'(tv[2]), 32'h0000);
        chk("t6_gr",  32'(grant), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/osd_cmd_sched.md
Name: osd_cmd_sched

Overview:
Schedules the 16-bit OSD command bus (opcode in [15:8], argument in [7:0]) for the overlay block. The overlay latches a command only when the bus value changes. Two requesters share the bus:
- requester A: MCU/SPI bridge.
- requester B: local status/text engine.
The block arbitrates between them, keeps multi-word bursts (x, y, char, attr; font streams) atomic, holds each word stable long enough to be sampled, and inserts a harmless separator word when a word equals the currently driven one, so repeated font bytes are not lost.

Parameters:
HOLD_CYCLES, 2, cycles each issued word (and each separator) is held on osd_command; minimum 1
LOCK_TIMEOUT, 4096, idle cycles inside a locked burst before the lock is force-released; 0 disables
TMR_W, 13, width of the hold/timeout counter; must cover both parameter values

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  asynchronous, active-high reset
a_cmd  in  16  requester A command word
a_valid  in  1  A word present
a_last  in  1  A word ends its burst (releases lock)
a_ready  out  1  A word accepted this cycle when a_valid&&a_ready
b_cmd  in  16  requester B command word
b_valid  in  1  B word present
b_last  in  1  B burst end
b_ready  out  1  B accept
osd_command  out  16  command bus to overlay, registered
busy  out  1  high whenever state != IDLE
grant  out  2  one-hot owner {B,A}; 00 when unlocked

Behaviour:
- Reset (async):
  - osd_command=16'h0000, state=IDLE, grant=00, busy=0.
  - Priority pointer = A. All counters = 0. Ready outputs low.
- States: IDLE, SEP, ISSUE, WAIT.
- Ready generation is combinational from state, grant, pointer and valid. Valid never depends on ready.
  - IDLE:
    - If only one requester is valid, that one gets ready.
    - If both are valid, the pointer owner gets ready.
  - WAIT: only the granted requester gets ready.
  - SEP, ISSUE: both ready outputs low.
- On accept (in IDLE or WAIT):
  - Latch word and last flag. Set grant to the accepted requester. Load timer=HOLD_CYCLES-1.
  - If word == current osd_command: next cycle osd_command={8'h00, ~osd_command[7:0]}, state SEP. Opcode 00 is undecoded and the low byte differs, so the overlay sees a change that has no effect.
  - Else: next cycle osd_command=word, state ISSUE.
- SEP:
  - Decrement timer; at 0 drive the latched word, reload timer, go to ISSUE.
  - Separator is held exactly HOLD_CYCLES cycles.
- ISSUE:
  - Word is held exactly HOLD_CYCLES cycles.
  - At timer 0:
    - If last: grant=00, pointer toggles to the other requester, go to IDLE.
    - Else: go to WAIT, clear timeout counter.
- WAIT:
  - Accept follows the rules above.
  - If LOCK_TIMEOUT!=0 and the counter reaches LOCK_TIMEOUT with no accept: grant=00, pointer toggles, go to IDLE. osd_command is unchanged.
- Timing:
  - Latency accept→word on bus: 1 cycle normally, 1+HOLD_CYCLES with a separator.
  - Max throughput: one word per HOLD_CYCLES+1 cycles (the accept cycle is in IDLE/WAIT).
- osd_command holds its value in IDLE/WAIT. It changes only on SEP/ISSUE entry.
- Simultaneous valid in IDLE: pointer decides. After a burst completes, the pointer points at the loser, giving round-robin at burst granularity.
- Lock: the granted requester keeps ownership across a burst. The other requester is stalled, however long its valid stays high.
- Separator compare uses the full 16 bits. 16'h0000 after reset counts as current, so a first word 16'h0000 gets separator 16'h00FF.
- Reset mid-burst: lock dropped, bus returns to 0000. Requesters must restart their bursts.

Decomposition:
- Shared package osd_pkg:
  - opcode constants OSD_OP_OVERLAY=8'h01, OSD_OP_POPUP=8'h02, OSD_OP_X=8'h10, OSD_OP_Y=8'h11, OSD_OP_CHAR=8'h12, OSD_OP_ATTR=8'h13, OSD_OP_FONT_RST=8'h20, OSD_OP_FONT_DATA=8'h21, OSD_OP_NOP=8'h00.
  - state encoding.
- One natural sub-module, osd_rr_arb2: 2-way round-robin arbiter with lock/release inputs, producing ready and the pointer. The FSM and bus register stay in osd_cmd_sched.

Test Plan:
- A sends single word 16'h0101 last=1 → bus 0101 one cycle after accept, held 2 cycles; then IDLE, grant 00, pointer=B.
- A sends burst 1005,1103,1241,1347 (last on 1347) while b_valid held with 0201 → B stalled; bus shows the four words in order; 0201 appears only after 1347 completes.
- A sends font stream 2001 then 21AA,21AA,21AA → bus sequence 2001, 21AA, 0055, 21AA, 0055, 21AA; every separator is held exactly HOLD_CYCLES.
- a_valid and b_valid asserted together in IDLE twice with last=1 → first grant A, second grant B.
- A sends burst word 1005 (last=0) then goes idle → after LOCK_TIMEOUT cycles grant=00 and a pending B word is accepted next; bus stays 1005 until B's word issues.
- Reset asserted in SEP mid-burst → osd_command=0000 immediately, grant=00, busy=0; a new A word 0000 after release yields separator 00FF then 0000.
